// File: rtl/cnt_seek_pkg.sv
// Shared types and constants for the counter seek controller.
package cnt_seek_pkg;

  localparam int unsigned CNT_SEEK_WIDTH = 4;
  localparam int unsigned DWELL_W        = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    STEP_UP   = 3'd2,
    STEP_DOWN = 3'd3,
    WAIT      = 3'd4,
    DONE      = 3'd5
  } seek_state_t;

endpackage

// File: rtl/cnt_seek_ctrl_if.sv
// Seek handshake, counter step commands and counter feedback in one bundle.
interface cnt_seek_ctrl_if
  import cnt_seek_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_SEEK_WIDTH
);
  logic             Start;
  logic [WIDTH-1:0] Target;
  logic             Abort;
  logic [WIDTH-1:0] Count;
  logic             Up;
  logic             Down;
  logic             Busy;
  logic             Done;
  logic             Error;

  modport master (
    output Start, Target, Abort, Count,
    input  Up, Down, Busy, Done, Error
  );

  modport slave (
    input  Start, Target, Abort, Count,
    output Up, Down, Busy, Done, Error
  );
endinterface

// File: rtl/cnt_dwell_timer.sv
// Loadable down-counter with a zero flag; paces the idle gap after each step.
module cnt_dwell_timer
  import cnt_seek_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_value,
  input  logic               en,
  output logic               zero
);
  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/cnt_seek_ctrl.sv
// Drives an up/down counter to a captured target with single-cycle step commands.
// Optional step-count timeout with sticky Error: define CNT_SEEK_TIMEOUT_EN.
module cnt_seek_ctrl
  import cnt_seek_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_SEEK_WIDTH,
  parameter int unsigned DWELL = 0
) (
  input logic            Clock,
  input logic            Reset,
  cnt_seek_ctrl_if.slave bus
);
  // Timer is loaded with DWELL-1 so WAIT exits on the cycle it reads zero.
  localparam logic [DWELL_W-1:0] DWELL_LOAD = (DWELL > 0) ? DWELL_W'(DWELL - 1) : '0;
  localparam logic               HAS_DWELL  = (DWELL > 0);

  seek_state_t      state;
  logic [WIDTH-1:0] target;
  logic             up_q;
  logic             down_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             stepping;
  logic             timeout;
  logic             dwell_zero;

  assign accept   = (state == IDLE) && bus.Start && !bus.Abort;
  assign stepping = (state == STEP_UP) || (state == STEP_DOWN);

  cnt_dwell_timer u_dwell (
    .clk        (Clock),
    .rst        (Reset),
    .load       (stepping && HAS_DWELL),
    .load_value (DWELL_LOAD),
    .en         (state == WAIT),
    .zero       (dwell_zero)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      target <= '0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target <= bus.Target;
            state  <= COMPARE;
            busy_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          if (bus.Abort || timeout) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            case (state)
              COMPARE: begin
                if (bus.Count == target) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                end else if (bus.Count < target) begin
                  state <= STEP_UP;
                  up_q  <= 1'b1;
                end else begin
                  state  <= STEP_DOWN;
                  down_q <= 1'b1;
                end
              end
              STEP_UP, STEP_DOWN: state <= HAS_DWELL ? WAIT : COMPARE;
              WAIT: begin
                if (dwell_zero) state <= COMPARE;
              end
              default: begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

`ifdef CNT_SEEK_TIMEOUT_EN
  // Fires on the 2^WIDTH-th step, which no undisturbed seek ever needs.
  localparam logic [WIDTH:0] STEP_LAST = {1'b0, {WIDTH{1'b1}}};
  logic [WIDTH:0] steps;
  logic           error_q;

  assign timeout = stepping && (steps == STEP_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      steps   <= '0;
      error_q <= 1'b0;
    end else if (accept) begin
      steps   <= '0;
      error_q <= 1'b0;
    end else begin
      if (stepping) steps <= steps + 1'b1;
      if (timeout && !bus.Abort) error_q <= 1'b1;
    end
  end

  assign bus.Error = error_q;
`else
  assign timeout   = 1'b0;
  assign bus.Error = 1'b0;
`endif

  assign bus.Up   = up_q;
  assign bus.Down = down_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_cnt_seek_ctrl.sv
// Closed-loop bench: two controllers (DWELL 0 and 2) each steering a 4-bit up/down counter.
module tb_cnt_seek_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  cnt_seek_ctrl_if #(.WIDTH(W)) b0 ();
  cnt_seek_ctrl_if #(.WIDTH(W)) b2 ();

  logic [W-1:0] cnt0 = '0;
  logic [W-1:0] cnt2 = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         up_dis = 1'b0;

  assign b0.Count = cnt0;
  assign b2.Count = cnt2;

  // Bench-side up/down counter, optionally with its Up input disconnected.
  always @(posedge clk) begin
    if (load) begin
      cnt0 <= load_val;
      cnt2 <= load_val;
    end else begin
      if (b0.Up && !up_dis) cnt0 <= cnt0 + 1'b1;
      else if (b0.Down)     cnt0 <= cnt0 - 1'b1;
      if (b2.Up && !up_dis) cnt2 <= cnt2 + 1'b1;
      else if (b2.Down)     cnt2 <= cnt2 - 1'b1;
    end
  end

  cnt_seek_ctrl #(.WIDTH(W), .DWELL(0)) dut0 (.Clock(clk), .Reset(rst), .bus(b0));
  cnt_seek_ctrl #(.WIDTH(W), .DWELL(2)) dut2 (.Clock(clk), .Reset(rst), .bus(b2));

  // Expected {Up,Down,Busy,Done} in cycle k after the accepting edge.
  function automatic logic [3:0] model_out(int k, int c0, int t, int dw, int a);
    int  d, p, dc, last;
    bit  aborted, stp;
    d       = (t > c0) ? t - c0 : c0 - t;
    p       = 2 + dw;
    dc      = d * p + 2;
    aborted = (a > 0) && (a < dc);
    last    = aborted ? a : dc;
    stp     = (k >= 2) && (k <= last) && (((k - 2) % p) == 0) && (((k - 2) / p) < d);
    return {stp && (t > c0), stp && (t < c0), (k >= 1) && (k <= last), !aborted && (k == dc)};
  endfunction

  function automatic int model_count(int c0, int t, int dw, int a);
    int d, p, dc, n;
    d  = (t > c0) ? t - c0 : c0 - t;
    p  = 2 + dw;
    dc = d * p + 2;
    n  = d;
    if ((a > 0) && (a < dc)) begin
      n = (a < 2) ? 0 : (a - 2) / p + 1;
      if (n > d) n = d;
    end
    return (t > c0) ? c0 + n : c0 - n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] t, input logic a);
    b0.Start = s;  b2.Start = s;
    b0.Target = t; b2.Target = t;
    b0.Abort = a;  b2.Abort = a;
  endtask

  task automatic preset(input logic [W-1:0] v);
    load = 1'b1;
    load_val = v;
    tick;
    load = 1'b0;
  endtask

  // Launches one seek, checks every cycle of both controllers, then the final counts.
  task automatic run_seek(input string name, input int t, input int a, input int mid);
    int c0a, c0b, d0, d2, kmax;
    logic [3:0] exp0, exp2, obs0, obs2;
    c0a  = int'(cnt0);
    c0b  = int'(cnt2);
    d0   = (t > c0a) ? t - c0a : c0a - t;
    d2   = (t > c0b) ? t - c0b : c0b - t;
    kmax = ((d0 * 2 + 2) > (d2 * 4 + 2) ? (d0 * 2 + 2) : (d2 * 4 + 2)) + 3;
    drive(1'b1, W'(t), 1'b0);
    tick;
    for (int k = 1; k <= kmax; k++) begin
      exp0 = model_out(k, c0a, t, 0, a);
      exp2 = model_out(k, c0b, t, 2, a);
      obs0 = {b0.Up, b0.Down, b0.Busy, b0.Done};
      obs2 = {b2.Up, b2.Down, b2.Busy, b2.Done};
      checks++;
      if (obs0 !== exp0) begin
        errors++;
        $display("FAIL %s dwell0 cycle %0d: up/down/busy/done got %b expected %b", name, k, obs0, exp0);
      end
      checks++;
      if (obs2 !== exp2) begin
        errors++;
        $display("FAIL %s dwell2 cycle %0d: up/down/busy/done got %b expected %b", name, k, obs2, exp2);
      end
      if (k == mid) drive(1'b1, W'(9), k == a);
      else          drive(1'b0, W'(t), k == a);
      tick;
    end
    drive(1'b0, W'(t), 1'b0);
    checks++;
    if (int'(cnt0) !== model_count(c0a, t, 0, a)) begin
      errors++;
      $display("FAIL %s dwell0 final count: got %0d expected %0d", name, cnt0, model_count(c0a, t, 0, a));
    end
    checks++;
    if (int'(cnt2) !== model_count(c0b, t, 2, a)) begin
      errors++;
      $display("FAIL %s dwell2 final count: got %0d expected %0d", name, cnt2, model_count(c0b, t, 2, a));
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({b0.Up, b0.Down, b0.Busy, b0.Done, b0.Error} !== 5'b0) begin
      errors++;
      $display("FAIL reset dwell0 outputs: got %b expected 00000", {b0.Up, b0.Down, b0.Busy, b0.Done, b0.Error});
    end
    checks++;
    if ({b2.Up, b2.Down, b2.Busy, b2.Done, b2.Error} !== 5'b0) begin
      errors++;
      $display("FAIL reset dwell2 outputs: got %b expected 00000", {b2.Up, b2.Down, b2.Busy, b2.Done, b2.Error});
    end
    #1 rst = 1'b0;
    tick;
  endtask

  task automatic test_step_up;
    preset(4'd3);
    run_seek("up_3_to_7", 7, 0, 0);
    checks++;
    if (cnt0 !== 4'd7) begin
      errors++;
      $display("FAIL up_3_to_7 count: got %0d expected 7", cnt0);
    end
  endtask

  task automatic test_step_down;
    preset(4'd9);
    run_seek("down_9_to_2", 2, 0, 0);
    checks++;
    if (cnt2 !== 4'd2) begin
      errors++;
      $display("FAIL down_9_to_2 dwell2 count: got %0d expected 2", cnt2);
    end
  endtask

  task automatic test_equal;
    preset(4'd5);
    run_seek("equal_5", 5, 0, 0);
  endtask

  task automatic test_abort;
    preset(4'd0);
    run_seek("abort_0_to_15", 15, 5, 0);
    checks++;
    if (cnt0 !== 4'd2) begin
      errors++;
      $display("FAIL abort count: got %0d expected 2", cnt0);
    end
    run_seek("after_abort_to_0", 0, 0, 0);
    checks++;
    if (cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL after_abort count: got %0d expected 0", cnt0);
    end
  endtask

  task automatic test_start_abort_idle;
    drive(1'b1, 4'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ((b0.Busy !== 1'b0) || (b2.Busy !== 1'b0)) begin
        errors++;
        $display("FAIL start_abort_idle busy: got %b%b expected 00", b0.Busy, b2.Busy);
      end
    end
    drive(1'b0, 4'd0, 1'b0);
    tick;
  endtask

  task automatic test_start_mid;
    preset(4'd1);
    run_seek("start_mid_seek", 6, 0, 3);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] held0, held2;
    preset(4'd0);
    drive(1'b1, 4'd15, 1'b0);
    tick;
    drive(1'b0, 4'd15, 1'b0);
    for (int k = 0; k < 4; k++) tick;
    #2 rst = 1'b1;
    held0 = cnt0;
    held2 = cnt2;
    #1;
    checks++;
    if ({b0.Up, b0.Down, b0.Busy, b0.Done, b0.Error, b2.Up, b2.Down, b2.Busy, b2.Done, b2.Error} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b%b expected all zero",
               {b0.Up, b0.Down, b0.Busy, b0.Done, b0.Error}, {b2.Up, b2.Down, b2.Busy, b2.Done, b2.Error});
    end
    tick;
    checks++;
    if ((cnt0 !== held0) || (cnt2 !== held2)) begin
      errors++;
      $display("FAIL reset_mid count: got %0d/%0d expected %0d/%0d", cnt0, cnt2, held0, held2);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_random;
    int t, a;
    for (int i = 0; i < 20; i++) begin
      preset(W'($urandom_range(0, 15)));
      t = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 24)) : 0;
      run_seek("random", t, a, 0);
    end
  endtask

`ifdef CNT_SEEK_TIMEOUT_EN
  task automatic test_timeout;
    int dones0, dones2;
    dones0 = 0;
    dones2 = 0;
    up_dis = 1'b1;
    preset(4'd0);
    drive(1'b1, 4'd4, 1'b0);
    tick;
    drive(1'b0, 4'd4, 1'b0);
    for (int k = 1; k <= 3 + 15 * 4 + 2; k++) begin
      if (b0.Done) dones0++;
      if (b2.Done) dones2++;
      if (k == 3 + 15 * 2) begin
        checks++;
        if ({b0.Error, b0.Busy} !== 2'b10) begin
          errors++;
          $display("FAIL timeout dwell0 error/busy: got %b expected 10", {b0.Error, b0.Busy});
        end
      end
      if (k == 3 + 15 * 4) begin
        checks++;
        if ({b2.Error, b2.Busy} !== 2'b10) begin
          errors++;
          $display("FAIL timeout dwell2 error/busy: got %b expected 10", {b2.Error, b2.Busy});
        end
      end
      tick;
    end
    checks++;
    if ((dones0 != 0) || (dones2 != 0)) begin
      errors++;
      $display("FAIL timeout done pulses: got %0d/%0d expected 0/0", dones0, dones2);
    end
    up_dis = 1'b0;
    drive(1'b1, 4'd0, 1'b0);
    tick;
    drive(1'b0, 4'd0, 1'b0);
    checks++;
    if ({b0.Error, b2.Error} !== 2'b00) begin
      errors++;
      $display("FAIL timeout clear error: got %b expected 00", {b0.Error, b2.Error});
    end
    for (int k = 0; k < 4; k++) tick;
  endtask
`endif

  initial begin
    drive(1'b0, 4'd0, 1'b0);
    test_reset;
    test_step_up;
    test_step_down;
    test_equal;
    test_abort;
    test_start_abort_idle;
    test_start_mid;
    test_reset_mid;
    test_random;
`ifdef CNT_SEEK_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
